tv80_alu16_seq: RTL

Sequencer that runs 16-bit Z80 arithmetic (ADD/ADC/SBC HL,ss) through the shared 8-bit TV80 ALU as two back-to-back byte passes: low byte first, then high byte. It sits between the core's microcode/register-file control and the combinational ALU. It drives the ALU's operation, bus and flag inputs. It captures the low-byte result and flags, then returns a registered 16-bit result and final flag byte with a start/done handshake.

---
 rtl/tv80_alu16_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tv80_alu16_seq.sv
// rtl/tv80_alu16_seq.sv - two-pass 16-bit ADD/ADC/SBC HL,ss sequencer over the 8-bit TV80 ALU
// Optional 16-bit compare (op 11) enabled by `TV80_ALU16_CMP_EN.
module tv80_alu16_seq #(
  parameter int Flag_C = 0,
  parameter int Flag_Z = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic        alu_arith16,
  output logic        alu_z16,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f_in,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SBC = 2'b10;
  localparam logic [1:0] OP_CP  = 2'b11;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_lat;
  logic [15:0] a_lat, b_lat;
  logic [7:0]  f_lat, q_lo, f_lo;
  logic        op_ok, accept, wr_result;

`ifdef TV80_ALU16_CMP_EN
  assign op_ok     = 1'b1;
  assign wr_result = (op_lat != OP_CP);
`else
  assign op_ok     = (op != OP_CP);
  assign wr_result = 1'b1;
`endif

  assign accept = (state == IDLE) && start && op_ok;
  assign busy   = (state == LO) || (state == HI);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LO;
      LO:      state_nxt = HI;
      HI:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_lat <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      f_lat  <= '0;
      q_lo   <= '0;
      f_lo   <= '0;
      result <= '0;
      f_out  <= '0;
    end else begin
      if (accept) begin
        op_lat <= op;
        a_lat  <= opa;
        b_lat  <= opb;
        f_lat  <= f_in;
      end
      if (state == LO) begin
        q_lo <= alu_q;
        f_lo <= alu_f_out;
      end
      if (state == HI) begin
        f_out <= alu_f_out;
        if (wr_result) result <= {alu_q, q_lo};
      end
    end
  end

  // High pass takes f_lo as flag input so carry and low-byte Z chain through the ALU.
  always_comb begin
    alu_op      = 4'b0000;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    alu_busa    = 8'h00;
    alu_busb    = 8'h00;
    alu_f_in    = 8'h00;
    case (state)
      LO: begin
        alu_busa = a_lat[7:0];
        alu_busb = b_lat[7:0];
        alu_f_in = f_lat;
        case (op_lat)
          OP_ADD: begin
            alu_op      = 4'b0000;
            alu_arith16 = 1'b1;
          end
          OP_ADC: alu_op = 4'b0001;
          OP_SBC: alu_op = 4'b0011;
`ifdef TV80_ALU16_CMP_EN
          OP_CP:  alu_op = 4'b0010;
`endif
          default: alu_op = 4'b0000;
        endcase
      end
      HI: begin
        alu_busa = a_lat[15:8];
        alu_busb = b_lat[15:8];
        alu_f_in = f_lo;
        case (op_lat)
          OP_ADD: begin
            alu_op      = 4'b0001;
            alu_arith16 = 1'b1;
          end
          OP_ADC: begin
            alu_op  = 4'b0001;
            alu_z16 = 1'b1;
          end
          OP_SBC: begin
            alu_op  = 4'b0011;
            alu_z16 = 1'b1;
          end
`ifdef TV80_ALU16_CMP_EN
          OP_CP: begin
            alu_op  = 4'b0011;
            alu_z16 = 1'b1;
          end
`endif
          default: alu_op = 4'b0000;
        endcase
      end
      default: ;
    endcase
  end

  // Integration checks on the attached ALU: 16-bit Z and ADD16 carry-out must be coherent.
  a_z16_coherent: assert property (@(posedge clk) disable iff (!reset_n)
    (done && (op_lat == OP_ADC || op_lat == OP_SBC)) |-> (f_out[Flag_Z] == (result == 16'h0000)));

  a_add_carry: assert property (@(posedge clk) disable iff (!reset_n)
    (done && op_lat == OP_ADD) |->
      ((({1'b0, a_lat} + {1'b0, b_lat}) >> 16) == 17'(f_out[Flag_C])));

endmodule
